// File: rtl/prog_mem.sv
// Program memory with a streaming load port and a one-cycle-latency fetch port.
// A load session writes a contiguous run of words starting at a base address.
// Fetches are rejected while a session is in progress, or when the address is
// outside the stored depth.

module prog_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              busy
);

  // Index width for the storage array; address bits above this are only
  // used for range checks, since every in-range address fits below DEPTH.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH expressed at the widths of the two range comparisons.
  localparam logic [ADDR_W+1:0] DEPTH_LD = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_RD = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;

  logic [ADDR_W+1:0] ld_end;
  logic              range_bad;
  logic              start_ok;
  logic              accept;
  logic              last_word;
  logic              rd_in_range;

  // The end of the requested run is computed two bits wider than the address
  // so that base + len can never overflow before it is compared with DEPTH.
  assign ld_end      = {2'b00, ld_base} + {1'b0, ld_len};
  assign range_bad   = (ld_end > DEPTH_LD);
  assign start_ok    = (state == IDLE) && ld_start && !range_bad;
  assign accept      = (state == LOAD) && ld_valid;
  assign last_word   = accept && (remaining == {{ADDR_W{1'b0}}, 1'b1});
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_RD);

  // State register; reset returns to IDLE and thereby aborts any session.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ld_start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (ld_len == '0) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: busy     = 1'b0;
      LOAD: ld_ready = 1'b1;
      DONE: ld_done  = 1'b1;
      default: busy  = 1'b1;
    endcase
  end

  // Session pointer and word counter, latched on an accepted start and
  // advanced once per accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (start_ok) begin
      ptr       <= ld_base;
      remaining <= ld_len;
    end else if (accept) begin
      ptr       <= ptr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // Range rejection pulse, raised the cycle after an out-of-range start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= (state == IDLE) && ld_start && range_bad;
    end
  end

  // Storage write; deliberately not reset so contents survive rst, and a word
  // presented in the same cycle as rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[ptr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Registered fetch; the read uses pre-edge contents, so a fetch issued with
  // a starting load sees the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if ((state != IDLE) || !rd_in_range) begin
        rd_err  <= 1'b1;
        rd_data <= '0;
      end else begin
        rd_err  <= 1'b0;
        rd_data <= mem[rd_addr[IDX_W-1:0]];
      end
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001: Parameter DATA_W, default 16, instruction word width in bits.
REQ-002: Parameter ADDR_W, default 12, address port width in bits.
REQ-003: Parameter DEPTH, default 16, number of stored words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004: clk  input  1  single clock; all state changes on its rising edge.
REQ-005: rst  input  1  reset, synchronous and active-high.
REQ-006: ld_start  input  1  one-cycle request to open a load session.
REQ-007: ld_base  input  ADDR_W  first write address, sampled with ld_start.
REQ-008: ld_len  input  ADDR_W+1  number of words to load, sampled with ld_start.
REQ-009: ld_valid  input  1  ld_data holds a word to write.
REQ-010: ld_data  input  DATA_W  word to write.
REQ-011: ld_ready  output  1  block accepts a word this cycle.
REQ-012: ld_done  output  1  one-cycle pulse: session completed.
REQ-013: ld_err  output  1  one-cycle pulse: ld_start rejected (range).
REQ-014: rd_en  input  1  fetch request.
REQ-015: rd_addr  input  ADDR_W  fetch address.
REQ-016: rd_data  output  DATA_W  fetched word, registered.
REQ-017: rd_valid  output  1  rd_data/rd_err valid this cycle.
REQ-018: rd_err  output  1  fetch rejected (range or busy).
REQ-019: busy  output  1  high whenever state is not IDLE.

Function
REQ-020: The block SHALL hold a DEPTH x DATA_W array and a 3-state FSM: IDLE, LOAD, DONE.
REQ-021: IDLE, ld_start=1, ld_base+ld_len (evaluated in ADDR_W+2 bits) > DEPTH: ld_err=1 next cycle, state stays IDLE, no write.
REQ-022: IDLE, ld_start=1, ld_len=0, range valid: next state DONE, no write.
REQ-023: IDLE, ld_start=1, ld_len>0, range valid: latch ptr=ld_base, remaining=ld_len, next state LOAD.
REQ-024: LOAD: ld_ready=1; ld_valid=1 writes mem[ptr]=ld_data, ptr+1, remaining-1 at that edge; ld_valid=0 stalls with no change.
REQ-025: LOAD: accepting the word that takes remaining to 0 SHALL move to DONE on the same edge.
REQ-026: ld_start in LOAD or DONE SHALL be ignored (no ld_err, no relatch).
REQ-027: DONE: ld_done=1 for exactly that one cycle, ld_ready=0, next state IDLE.
REQ-028: ld_ready SHALL be 0 outside LOAD; ptr never wraps (guaranteed by REQ-021).
REQ-029: Fetch latency 1 cycle: rd_en=1 at edge N gives rd_valid=1 in cycle N+1.
REQ-030: Fetch with busy=0 and rd_addr < DEPTH: rd_data=mem[rd_addr], rd_err=0.
REQ-031: Fetch with rd_addr >= DEPTH or busy=1: rd_data=0, rd_err=1, rd_valid=1.
REQ-032: rd_en=0: rd_valid=0, rd_err=0, rd_data holds its previous value.
REQ-033: Fetch and ld_start in the same IDLE cycle SHALL both be serviced; the fetch sees pre-load contents.
REQ-034: Back-to-back fetches SHALL sustain one result per cycle.

Reset
REQ-035: rst=1 at an edge: state=IDLE, ptr=0, remaining=0, ld_ready=0, ld_done=0, ld_err=0, rd_valid=0, rd_err=0, rd_data=0, busy=0.
REQ-036: Memory contents SHALL NOT be cleared by rst; words written before reset remain readable.
REQ-037: rst during LOAD aborts the session with no ld_done; rst dominates all other inputs in that cycle.

Verification
REQ-038: Load base=2, len=3, data 0xA001,0xA002,0xA003 with ld_valid gaps -> ld_done one cycle after third accept; fetches of 2,3,4 return those values, rd_valid 1 cycle after rd_en.
REQ-039: ld_start base=14, len=3 (DEPTH=16) -> ld_err pulse, busy stays 0, mem[14] unchanged.
REQ-040: ld_start len=0 -> busy for 1 cycle, ld_done next cycle, no write.
REQ-041: Fetch addr 16 (DEPTH=16) -> rd_valid=1, rd_err=1, rd_data=0; fetch during LOAD -> rd_err=1.
REQ-042: rst after 1 of 4 words accepted -> busy=0 next cycle, no ld_done, written word readable, remaining addresses keep old values.
REQ-043: Continuous rd_en over addrs 0..15 after full load -> 16 consecutive valid results, data matching loaded pattern.
